sine_rom_arbiter: RTL
=====================

# sine_rom_arbiter

Shares one single-port synchronous sine ROM between two address generators (for example the two phase counters of a dual-tone signal generator). Each cycle it grants the ROM to at most one requester and drives the ROM address. It returns the ROM word to the granted channel through a registered output with a valid strobe. It sits between the counters and the `rom` instance, replacing a dual-port ROM with one port plus this block.

## Interface
- `A_WIDTH`, default 8: ROM address width.
- `D_WIDTH`, default 8: ROM data width.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: arbitration enable. When low, no grants are issued; in-flight reads still complete.
- `req1`, input, 1: channel 1 request. Held high, with `addr1` stable, until `gnt1` is seen.
- `addr1`, input, A_WIDTH: channel 1 ROM address.
- `gnt1`, output, 1: combinational grant to channel 1 for the current cycle.
- `dout1`, output, D_WIDTH: last ROM word returned to channel 1.
- `valid1`, output, 1: one-cycle strobe; `dout1` was updated this cycle.
- `req2`, `addr2`, `gnt2`, `dout2`, `valid2`: channel 2 equivalents, with identical widths.
- `rom_addr`, output, A_WIDTH: address to the ROM, sampled by the ROM on the rising edge.
- `rom_data`, input, D_WIDTH: ROM read data, valid the cycle after the address is sampled.

## Operation
- **Grant logic (combinational):** `gnt1`/`gnt2` are one-hot or zero, and never both high.
  - A grant is issued only when `en`=1 and the corresponding `req`=1.
  - Single requester: that requester is granted.
  - Both requesting: winner is chosen per the Configuration section.
- **`rom_addr`:**
  - Equals `addr1` when `gnt1`=1.
  - Equals `addr2` when `gnt2`=1.
  - Otherwise holds the last granted address (registered copy, reset 0). This avoids needless ROM toggling.
- **Return pipeline:** two stages of tag registers.
  - Stage A (`tag_a`, 2 bits), loaded each edge with {`gnt2`,`gnt1`}.
  - Stage B, at the next edge: if `tag_a[0]`, then `dout1` <= `rom_data` and `valid1` <= 1. Otherwise `valid1` <= 0. Channel 2 uses `tag_a[1]` in the same way.
  - `dout1`/`dout2` hold their value between strobes.
- **Throughput:** one grant per cycle total. Back-to-back grants to the same or alternating channels are supported with no bubble.
- **Round-robin pointer `last_q`:** updated only on a cycle with a grant; records the channel granted.

## Timing
- **Latency:** grant in cycle N, `valid` high in cycle N+2 with the matching `dout`. Responses return in grant order.
- **Reset values:**
  - `dout1` = `dout2` = 0, `valid1` = `valid2` = 0.
  - `tag_a` = 0, `rom_addr` register = 0.
  - `last_q` = channel 2, so channel 1 wins the first contention.
- **Reset mid-operation:** all in-flight reads are discarded and no `valid` is emitted for them. Grants resume the first cycle after `rst` deasserts.
- **`en` falling while reads are in flight:** pending `valid` strobes still appear on schedule.
- **`req` dropped without a grant:** legal; no state change results.
- **Address wrap:** the address is passed through unmodified. The arbiter does no arithmetic on it.

## Configuration
- `SINE_ARB_RR_EN` defined: round-robin. On contention, grant the channel not equal to `last_q`. Two continuously requesting channels alternate 1,2,1,2…
- `SINE_ARB_RR_EN` undefined: fixed priority. Channel 1 always wins contention, and `last_q` is omitted. A continuously requesting channel 1 starves channel 2. This is accepted in that build.

## Test plan
- **Single-channel read:** after reset, `req1`=1 with `addr1`=0x40 for one cycle, and the ROM model holds 0xFF at 0x40. Expect `gnt1`=1 and `rom_addr`=0x40 in cycle N. In N+2, expect `valid1`=1 and `dout1`=0xFF; `valid2` stays 0.
- **Contention, round-robin:** `SINE_ARB_RR_EN` defined, both requesting continuously with `addr1`=0x00 and `addr2`=0x80. Expect grants 1,2,1,2 and `dout1`=rom[0x00], `dout2`=rom[0x80] on alternating cycles.
- **Contention, fixed priority:** macro undefined, same stimulus. Expect `gnt1`=1 every cycle, `gnt2` never asserted, and `valid1` high continuously from cycle 2.
- **Enable gating:** `en`=0 with both requesting for 5 cycles. Expect no grants and `rom_addr` unchanged. Raise `en`; expect the first grant the same cycle, and `valid` 2 cycles later.
- **Reset mid-flight:** grant channel 2 in cycle N, then assert `rst` in N+1. Expect `valid2` never asserted and `dout2`=0. After release, a new `req1` at 0x10 returns rom[0x10] with latency 2.
- **Back-to-back same channel:** `req1` held with `addr1` stepping 0,1,2,3 on each grant. Expect `valid1` high for 4 consecutive cycles with `dout1` = rom[0..3] in order.

Source files
------------

// File: rtl/sine_rom_arbiter.sv
// sine_rom_arbiter: shares one single-port synchronous sine ROM between two
// address generators. Grants are combinational and at most one per cycle.
// Read data returns to the granted channel two cycles later with a strobe.
// Build option: define SINE_ARB_RR_EN for round-robin contention handling.
// Without it, channel 1 has fixed priority and channel 2 may starve.
module sine_rom_arbiter #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               req1,
    input  logic [A_WIDTH-1:0] addr1,
    output logic               gnt1,
    output logic [D_WIDTH-1:0] dout1,
    output logic               valid1,
    input  logic               req2,
    input  logic [A_WIDTH-1:0] addr2,
    output logic               gnt2,
    output logic [D_WIDTH-1:0] dout2,
    output logic               valid2,
    output logic [A_WIDTH-1:0] rom_addr,
    input  logic [D_WIDTH-1:0] rom_data
);

    // Last address that was granted; rom_addr falls back to it when idle
    logic [A_WIDTH-1:0] addr_q;
    // Stage A tag: which channel owns the ROM read now in flight
    logic [1:0]         tag_a;
    // High when channel 1 should win a contention this cycle
    logic               prio1;

`ifdef SINE_ARB_RR_EN
    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } chan_t;

    chan_t last_q;

    // Remember which channel was served most recently; starts as channel 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= CH2;
        end else if (gnt1) begin
            last_q <= CH1;
        end else if (gnt2) begin
            last_q <= CH2;
        end
    end

    assign prio1 = (last_q == CH2);
`else
    assign prio1 = 1'b1;
`endif

    // Grant decision: nothing while in reset or disabled, otherwise one winner
    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (!rst && en) begin
            if (req1 && (!req2 || prio1)) begin
                gnt1 = 1'b1;
            end else if (req2) begin
                gnt2 = 1'b1;
            end
        end
    end

    // ROM address follows the winner, else parks on the last granted address
    always_comb begin
        rom_addr = addr_q;
        if (gnt1) begin
            rom_addr = addr1;
        end else if (gnt2) begin
            rom_addr = addr2;
        end
    end

    // Capture the granted address so the ROM input stays quiet while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (gnt1 || gnt2) begin
            addr_q <= rom_addr;
        end
    end

    // Tag the read issued this cycle so its data can be routed next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_a <= 2'b00;
        end else begin
            tag_a <= {gnt2, gnt1};
        end
    end

    // Route returning ROM data to its owner and strobe that channel's valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1  <= '0;
            dout2  <= '0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
        end else begin
            valid1 <= tag_a[0];
            valid2 <= tag_a[1];
            if (tag_a[0]) begin
                dout1 <= rom_data;
            end
            if (tag_a[1]) begin
                dout2 <= rom_data;
            end
        end
    end

endmodule
